rs_decode_sequencer: RTL

Frame-level sequencer for the RS(15,11) GF(16) decoder. It accepts one 15-symbol codeword, drives the syndrome unit, and starts the Euclid controller and the Chien/Forney unit in turn. It owns the frame buffer, applies error corrections to it, and streams out the 11 corrected message symbols with a per-frame status flag. It sits between the input stream and the existing syndrome, Euclid and Chien blocks.

---
 rtl/rs_decode_sequencer_if.sv | 43 ++++
 rtl/rs_decode_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_decode_sequencer_if.sv
// Signal bundle between the RS(15,11) frame sequencer and the input stream,
// syndrome, Euclid and Chien/Forney blocks and the output stream.
// Valid/ready: a symbol moves on a rising edge where valid and ready are both
// high; the producer holds valid and data stable until then, and ready never
// depends on valid in the same cycle.
interface rs_decode_sequencer_if #(
   parameter int SYM_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [SYM_W-1:0] in_sym;
   logic             syn_clr;
   logic             syn_en;
   logic             syn_done;
   logic             syn_zero;
   logic             euc_start;
   logic             euc_done;
   logic [1:0]       euc_deg;
   logic             chien_step;
   logic [3:0]       chien_idx;
   logic             chien_hit;
   logic [SYM_W-1:0] chien_mag;
   logic             out_valid;
   logic             out_ready;
   logic [SYM_W-1:0] out_sym;
   logic             out_last;
   logic             out_uncorr;
   logic             busy;

   modport master (
      input  in_valid, in_sym, syn_done, syn_zero, euc_done, euc_deg,
             chien_hit, chien_mag, out_ready,
      output in_ready, syn_clr, syn_en, euc_start, chien_step, chien_idx,
             out_valid, out_sym, out_last, out_uncorr, busy
   );

   modport slave (
      output in_valid, in_sym, syn_done, syn_zero, euc_done, euc_deg,
             chien_hit, chien_mag, out_ready,
      input  in_ready, syn_clr, syn_en, euc_start, chien_step, chien_idx,
             out_valid, out_sym, out_last, out_uncorr, busy
   );
endinterface

// File: rtl/rs_decode_sequencer.sv
// Frame sequencer for the RS(15,11) GF(16) decoder: load, syndrome, Euclid, Chien
// correction and message output. Define RS_SEQ_STATS_EN to add frame statistics.
module rs_decode_sequencer #(
   parameter int N       = 15,
   parameter int K       = 11,
   parameter int SYM_W   = 4,
   parameter int TIMEOUT = 32
) (
   input  logic                  CLK,
   input  logic                  RESET,
   rs_decode_sequencer_if.master bus,
   output logic [2:0]            fsm_state
`ifdef RS_SEQ_STATS_EN
   ,
   output logic [15:0]           stat_frames,
   output logic [15:0]           stat_corrected,
   output logic [15:0]           stat_failed
`endif
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SYND  = 3'd2,
      EUCL  = 3'd3,
      CHIEN = 3'd4,
      OUT   = 3'd5
   } state_t;

   localparam int            TW       = $clog2(TIMEOUT);
   localparam logic [3:0]    LAST_IN  = 4'(N - 1);
   localparam logic [3:0]    LAST_OUT = 4'(K - 1);
   localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

   state_t           state, state_n;
   logic [3:0]       cnt, cnt_n;
   logic [TW-1:0]    tcnt, tcnt_n;
   logic             fail, fail_n;
   logic [1:0]       deg, deg_n;
   logic [1:0]       hits, hits_n;
   logic [1:0]       hit_cnt;
   logic             timeout;
   logic             wr_en;
   logic [3:0]       wr_idx;
   logic [SYM_W-1:0] wr_data;
   logic [SYM_W-1:0] frame_buf [N];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
         cnt   <= '0;
         tcnt  <= '0;
         fail  <= 1'b0;
         deg   <= '0;
         hits  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         tcnt  <= tcnt_n;
         fail  <= fail_n;
         deg   <= deg_n;
         hits  <= hits_n;
      end
   end

   // Frame contents are don't-care after reset, so the buffer has no reset.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         frame_buf[wr_idx] <= wr_data;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      tcnt_n  = '0;
      fail_n  = fail;
      deg_n   = deg;
      hits_n  = hits;
      hit_cnt = hits;
      timeout = (tcnt == T_LAST);
      wr_en   = 1'b0;
      wr_idx  = cnt;
      wr_data = bus.in_sym;

      bus.in_ready   = 1'b0;
      bus.syn_clr    = 1'b0;
      bus.syn_en     = 1'b0;
      bus.euc_start  = 1'b0;
      bus.chien_step = 1'b0;
      bus.chien_idx  = '0;
      bus.out_valid  = 1'b0;
      bus.out_sym    = '0;
      bus.out_last   = 1'b0;
      bus.out_uncorr = 1'b0;

      case (state)
         IDLE: begin
            // Gated so every output reads 0 while reset is held.
            bus.syn_clr = ~RESET;
            state_n     = LOAD;
            cnt_n       = '0;
            fail_n      = 1'b0;
            deg_n       = '0;
            hits_n      = '0;
         end
         LOAD: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               bus.syn_en = 1'b1;
               wr_en      = 1'b1;
               if (cnt == LAST_IN) begin
                  cnt_n   = '0;
                  state_n = SYND;
               end else begin
                  cnt_n = cnt + 4'd1;
               end
            end
         end
         SYND: begin
            if (bus.syn_done) begin
               if (bus.syn_zero) begin
                  state_n = OUT;
               end else begin
                  bus.euc_start = 1'b1;
                  state_n       = EUCL;
               end
            end else if (timeout) begin
               fail_n  = 1'b1;
               state_n = OUT;
            end else begin
               tcnt_n = tcnt + 1'b1;
            end
         end
         EUCL: begin
            if (bus.euc_done) begin
               if (bus.euc_deg == 2'd3) begin
                  fail_n  = 1'b1;
                  state_n = OUT;
               end else begin
                  deg_n   = bus.euc_deg;
                  hits_n  = '0;
                  cnt_n   = '0;
                  state_n = CHIEN;
               end
            end else if (timeout) begin
               fail_n  = 1'b1;
               state_n = OUT;
            end else begin
               tcnt_n = tcnt + 1'b1;
            end
         end
         CHIEN: begin
            bus.chien_step = 1'b1;
            bus.chien_idx  = cnt;
            if (bus.chien_hit) begin
               wr_en   = 1'b1;
               wr_data = frame_buf[cnt] ^ bus.chien_mag;
               hit_cnt = (hits == 2'd3) ? hits : hits + 2'd1;
            end
            hits_n = hit_cnt;
            // Corrections already written stay in the buffer even on a count mismatch.
            if (cnt == LAST_IN) begin
               if (hit_cnt != deg) begin
                  fail_n = 1'b1;
               end
               cnt_n   = '0;
               state_n = OUT;
            end else begin
               cnt_n = cnt + 4'd1;
            end
         end
         OUT: begin
            bus.out_valid  = 1'b1;
            bus.out_sym    = frame_buf[cnt];
            bus.out_last   = (cnt == LAST_OUT);
            bus.out_uncorr = fail & (cnt == LAST_OUT);
            if (bus.out_ready) begin
               if (cnt == LAST_OUT) begin
                  fail_n  = 1'b0;
                  cnt_n   = '0;
                  state_n = IDLE;
               end else begin
                  cnt_n = cnt + 4'd1;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.busy  = (state != IDLE);
   assign fsm_state = state;

`ifdef RS_SEQ_STATS_EN
   logic frame_end;
   assign frame_end = (state == OUT) & bus.out_ready & (cnt == LAST_OUT);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         stat_frames    <= '0;
         stat_corrected <= '0;
         stat_failed    <= '0;
      end else if (frame_end) begin
         if (stat_frames != 16'hFFFF) begin
            stat_frames <= stat_frames + 16'd1;
         end
         if ((hits != 2'd0) && !fail && (stat_corrected != 16'hFFFF)) begin
            stat_corrected <= stat_corrected + 16'd1;
         end
         if (fail && (stat_failed != 16'hFFFF)) begin
            stat_failed <= stat_failed + 16'd1;
         end
      end
   end
`endif

endmodule
